// File: rtl/antilog_iter_pkg.sv
// Shared constants, log2(1-2^-i) table and FSM state type for the antilog unit.
package antilog_iter_pkg;

    localparam int unsigned TABLE_DEPTH = 10;
    localparam int unsigned ENTRY_W     = 16;
    localparam int unsigned IDX_W       = 4;

    localparam logic [15:0] ONE_Q15 = 16'h8000;

    // bit15 = sign (all entries negative), bits[7:0] = fraction of log2(1-2^-i)
    localparam logic [ENTRY_W-1:0] LOG_TABLE [TABLE_DEPTH] = '{
        16'h8100, 16'h806A, 16'h8031, 16'h8017, 16'h800B,
        16'h8005, 16'h8002, 16'h8001, 16'h8000, 16'h8000
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/antilog_iter_lut.sv
// Combinational ROM over LOG_TABLE; index i selects entry i (1-based), others read 0.
module antilog_lut
    import antilog_iter_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    output logic [ENTRY_W-1:0] entry_o
);

    always_comb begin
        entry_o = '0;
        case (idx_i)
            4'd1:    entry_o = LOG_TABLE[0];
            4'd2:    entry_o = LOG_TABLE[1];
            4'd3:    entry_o = LOG_TABLE[2];
            4'd4:    entry_o = LOG_TABLE[3];
            4'd5:    entry_o = LOG_TABLE[4];
            4'd6:    entry_o = LOG_TABLE[5];
            4'd7:    entry_o = LOG_TABLE[6];
            4'd8:    entry_o = LOG_TABLE[7];
            4'd9:    entry_o = LOG_TABLE[8];
            4'd10:   entry_o = LOG_TABLE[9];
            default: entry_o = '0;
        endcase
    end

endmodule

// File: rtl/antilog_iter.sv
// Iterative y = 2^(-x): shift-and-subtract normalisation on the fraction, then integer shift.
module antilog_iter
    import antilog_iter_pkg::*;
#(
    parameter int unsigned XLEN_PIXEL = 8,
    parameter int unsigned ITERATOR   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*XLEN_PIXEL-1:0] x_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*XLEN_PIXEL-1:0] y_out
);

    localparam int unsigned W  = 2 * XLEN_PIXEL;
    localparam int unsigned RW = XLEN_PIXEL + 1;
    localparam int unsigned MW = ENTRY_W - 1;

    state_e                state_q, state_d;
    logic [XLEN_PIXEL-1:0] k_q, k_d;
    logic [RW-1:0]         r_q, r_d;
    logic [W-1:0]          y_q, y_d;
    logic [IDX_W-1:0]      i_q, i_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [ENTRY_W-1:0]    entry;
    logic [MW-1:0]         mag;
    logic                  take;

    antilog_lut u_lut (
        .idx_i   (i_q),
        .entry_o (entry)
    );

    assign mag  = entry[MW-1:0];
    assign take = entry[ENTRY_W-1] && (mag != '0) && (MW'(r_q) >= mag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            r_q         <= '0;
            y_q         <= '0;
            i_q         <= IDX_W'(1);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            r_q         <= r_d;
            y_q         <= y_d;
            i_q         <= i_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        y_d     = y_q;
        i_d     = i_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    k_d     = x_in[W-1:XLEN_PIXEL];
                    r_d     = {1'b0, x_in[XLEN_PIXEL-1:0]};
                    y_d     = W'(ONE_Q15);
                    i_d     = IDX_W'(1);
                    state_d = ITER;
                end
            end
            ITER: begin
                if (take) begin
                    r_d = r_q - RW'(mag);
                    y_d = y_q - (y_q >> i_q);
                end
                i_d = i_q + IDX_W'(1);
                if (i_q == IDX_W'(ITERATOR)) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                y_d     = (k_q >= XLEN_PIXEL'(W)) ? '0 : (y_q >> k_q);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;

endmodule
